// File: rtl/async_gray_chan_dst.sv
// -----------------------------------------------------------------------------
// async_gray_chan_dst
//   Destination (SoC-domain) end of one gray-pointer asynchronous FIFO channel.
//   Samples the source's gray write pointer through a flop synchroniser,
//   presents the head slot as a valid/ready stream, and hands back a gray read
//   pointer so the source can reuse slots that have been consumed.
//
// Ports
//   clk_i         destination clock
//   rst_ni        asynchronous active-low reset
//   async_wptr_i  gray write pointer from the source domain (LOG_DEPTH+1 bits)
//   async_data_i  source slot array, slot k at [k*DATA_WIDTH +: DATA_WIDTH]
//   async_rptr_o  gray read pointer to the source domain (registered)
//   dst_data_o    head-of-queue beat
//   dst_valid_o   head beat valid (register-only path)
//   dst_ready_i   consumer accepts the head beat
//   fill_o        entries visible to this domain, 0..2**LOG_DEPTH
// -----------------------------------------------------------------------------
module async_gray_chan_dst #(
    parameter int DATA_WIDTH  = 8,
    parameter int LOG_DEPTH   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [LOG_DEPTH:0]                    async_wptr_i,
    input  logic [(2**LOG_DEPTH)*DATA_WIDTH-1:0]  async_data_i,
    output logic [LOG_DEPTH:0]                    async_rptr_o,
    output logic [DATA_WIDTH-1:0]                 dst_data_o,
    output logic                                  dst_valid_o,
    input  logic                                  dst_ready_i,
    output logic [LOG_DEPTH:0]                    fill_o
);

    localparam int PW    = LOG_DEPTH + 1;
    localparam int DEPTH = 2 ** LOG_DEPTH;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] r_wptr_sync [SYNC_STAGES];
    logic [PW-1:0] r_rptr_bin;
    logic [PW-1:0] r_rptr_gray;

    logic [PW-1:0] w_wptr_sync;
    logic [PW-1:0] w_wptr_bin;
    logic [PW-1:0] w_rptr_next;
    logic          w_empty;
    logic          w_pop;

    assign w_wptr_sync = r_wptr_sync[SYNC_STAGES-1];

    // Gray pointers differ only when entries exist, so a full-width compare
    // is enough; the MSB keeps empty and full apart across the wrap.
    assign w_empty     = (w_wptr_sync == r_rptr_gray);
    assign dst_valid_o = !w_empty;
    assign w_pop       = dst_valid_o && dst_ready_i;
    assign w_rptr_next = r_rptr_bin + PW'(w_pop);

    assign w_wptr_bin  = gray2bin(w_wptr_sync);
    assign fill_o      = w_wptr_bin - r_rptr_bin;

    assign async_rptr_o = r_rptr_gray;

    // Each bit is synchronised on its own; the gray source guarantees at most
    // one bit is in flight, so a skewed capture lands on old or new value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_wptr_sync[s] <= '0;
            end
        end else begin
            r_wptr_sync[0] <= async_wptr_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_wptr_sync[s] <= r_wptr_sync[s-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rptr_bin  <= '0;
            r_rptr_gray <= '0;
        end else begin
            r_rptr_bin  <= w_rptr_next;
            r_rptr_gray <= w_rptr_next ^ (w_rptr_next >> 1);
        end
    end

    // Head slot mux; a single-slot channel has no index bits at all.
    generate
        if (LOG_DEPTH == 0) begin : g_single
            assign dst_data_o = async_data_i;
        end else begin : g_mux
            logic [DATA_WIDTH-1:0] w_slots [DEPTH];
            for (genvar k = 0; k < DEPTH; k++) begin : g_slot
                assign w_slots[k] = async_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
            assign dst_data_o = w_slots[r_rptr_bin[LOG_DEPTH-1:0]];
        end
    endgenerate

`ifndef SYNTHESIS
    a_fill_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
        int'(fill_o) <= DEPTH);

    a_wptr_one_bit : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $countones(w_wptr_sync ^ $past(w_wptr_sync)) <= 1);

    a_data_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (dst_valid_o && !dst_ready_i) |=> (dst_valid_o && $stable(dst_data_o)));
`endif

endmodule

// File: tb/tb_async_gray_chan_dst.sv
// -----------------------------------------------------------------------------
// tb_async_gray_chan_dst
//   Plays the source side of the channel and compares the destination against
//   a transaction-level model: a queue of written beats, counters of writes
//   and pops, and a SYNC_STAGES-deep history of the write count that stands in
//   for synchroniser latency.
// -----------------------------------------------------------------------------
module tb_async_gray_chan_dst;

    localparam int DW    = 8;
    localparam int LD    = 1;
    localparam int SS    = 2;
    localparam int PW    = LD + 1;
    localparam int DEPTH = 2 ** LD;
    localparam int PMOD  = 2 ** PW;

    logic                  clk_i;
    logic                  rst_ni;
    logic [PW-1:0]         async_wptr_i;
    logic [DEPTH*DW-1:0]   async_data_i;
    logic [PW-1:0]         async_rptr_o;
    logic [DW-1:0]         dst_data_o;
    logic                  dst_valid_o;
    logic                  dst_ready_i;
    logic [PW-1:0]         fill_o;

    async_gray_chan_dst #(
        .DATA_WIDTH (DW),
        .LOG_DEPTH  (LD),
        .SYNC_STAGES(SS)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .async_wptr_i(async_wptr_i),
        .async_data_i(async_data_i),
        .async_rptr_o(async_rptr_o),
        .dst_data_o  (dst_data_o),
        .dst_valid_o (dst_valid_o),
        .dst_ready_i (dst_ready_i),
        .fill_o      (fill_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state
    int       wr_total;
    int       pop_total;
    int       hist[$];
    logic [7:0] exp_q[$];
    logic [PW-1:0] prev_rptr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] to_gray(input int n);
        logic [PW-1:0] b;
        b = PW'(n % PMOD);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        wr_total  = 0;
        pop_total = 0;
        hist.delete();
        for (int i = 0; i < SS; i++) hist.push_back(0);
        exp_q.delete();
        prev_rptr = '0;
    endtask

    // One cycle of activity, called at a falling edge. Returns whether the
    // requested write was accepted (source refuses writes when full).
    task automatic step(input bit wr, input logic [7:0] d, input bit rdy, output bit written);
        int vis;
        int exp_fill;
        bit pop;
        dst_ready_i = rdy;
        #1;
        vis      = hist[0];
        exp_fill = vis - pop_total;
        check("fill",  32'(fill_o), 32'(exp_fill));
        check("valid", 32'(dst_valid_o), 32'(exp_fill != 0));
        check("rptr",  32'(async_rptr_o), 32'(to_gray(pop_total)));
        check("rptr_1bit", 32'($countones(async_rptr_o ^ prev_rptr) <= 1), 32'd1);
        prev_rptr = async_rptr_o;
        if (exp_fill != 0) check("data", 32'(dst_data_o), 32'(exp_q[0]));
        pop = (exp_fill != 0) && rdy;
        written = 1'b0;
        if (wr && (wr_total - pop_total) < DEPTH) begin
            async_data_i[(wr_total % DEPTH)*DW +: DW] = d;
            wr_total++;
            async_wptr_i = to_gray(wr_total);
            exp_q.push_back(d);
            written = 1'b1;
        end
        if (pop) begin
            void'(exp_q.pop_front());
            pop_total++;
        end
        void'(hist.pop_front());
        hist.push_back(wr_total);
        @(negedge clk_i);
    endtask

    task automatic idle(input int n, input bit rdy);
        bit w;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy, w);
    endtask

    task automatic push_stream(input int first, input int cnt, input bit rdy);
        bit w;
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < cnt && guard < 200) begin
            step(1'b1, 8'(first + i), rdy, w);
            if (w) i++;
            guard++;
        end
        check("stream_done", 32'(i), 32'(cnt));
    endtask

    initial begin
        bit w;
        rst_ni       = 1'b0;
        async_wptr_i = '0;
        async_data_i = '0;
        dst_ready_i  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_valid", 32'(dst_valid_o), 32'd0);
        check("rst_rptr",  32'(async_rptr_o), 32'd0);
        check("rst_fill",  32'(fill_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Reset, no activity
        idle(6, 1'b1);

        // Single beat 0xA5
        step(1'b1, 8'hA5, 1'b1, w);
        idle(5, 1'b1);

        // Backpressure: two beats held, then drained back to back
        step(1'b1, 8'h11, 1'b0, w);
        step(1'b1, 8'h22, 1'b0, w);
        idle(5, 1'b0);
        check("bp_fill", 32'(fill_o), 32'd2);
        idle(5, 1'b1);

        // Wrap: ten beats with ready held high
        push_stream(0, 10, 1'b1);
        idle(5, 1'b1);

        // Reset mid-stream with two entries buffered
        step(1'b1, 8'h55, 1'b0, w);
        step(1'b1, 8'h66, 1'b0, w);
        idle(4, 1'b0);
        check("pre_rst_fill", 32'(fill_o), 32'd2);
        #2;
        rst_ni       = 1'b0;
        async_wptr_i = '0;
        #1;
        check("mid_rst_valid", 32'(dst_valid_o), 32'd0);
        check("mid_rst_fill",  32'(fill_o), 32'd0);
        check("mid_rst_rptr",  32'(async_rptr_o), 32'd0);
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(1'b1, 8'h3C, 1'b0, w);
        idle(3, 1'b0);
        check("post_rst_data", 32'(dst_data_o), 32'h3C);
        idle(3, 1'b1);

        // Randomised traffic with varying write and ready densities
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 400; i++) begin
                bit wr;
                bit rdy;
                wr  = ($urandom_range(0, 3) < (ph + 1)) ? 1'b1 : 1'b0;
                rdy = ($urandom_range(0, 3) < (4 - ph)) ? 1'b1 : 1'b0;
                step(wr, 8'($urandom), rdy, w);
            end
        end
        idle(6, 1'b1);
        check("final_empty", 32'(dst_valid_o), 32'd0);
        check("final_count", 32'(pop_total), 32'(wr_total));

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
